// File: rtl/axis_hit_pkg.sv
// Shared widths, constants and state encoding for the hit splitter.
// Referenced by axis_hit_splitter (optional macro AXIS_HIT_SPLITTER_EMPTY_BEAT_EN).
package axis_hit_pkg;

  localparam int MASK_WIDTH = 66;
  localparam int HDR_WIDTH  = 62;
  localparam int IDX_WIDTH  = 7;
  localparam int STS_WIDTH  = 16;
  localparam int CFG_WIDTH  = 8;

  // Output beat layout: {2'b00, header, index byte}
  localparam int OUT_IDX_LSB = 0;
  localparam int OUT_IDX_W   = 8;
  localparam int OUT_HDR_LSB = OUT_IDX_LSB + OUT_IDX_W;
  localparam int OUT_PAD_LSB = OUT_HDR_LSB + HDR_WIDTH;
  localparam int OUT_W       = 72;

  localparam logic [OUT_IDX_W-1:0] EMPTY_IDX = 8'h7F;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/axis_hit_splitter_lsb_priority_encoder.sv
// Combinational lowest-set-bit finder: index, one-hot of that bit, and any-set flag.
module lsb_priority_encoder
  import axis_hit_pkg::*;
(
  input  logic [MASK_WIDTH-1:0] mask,
  output logic [IDX_WIDTH-1:0]  idx,
  output logic [MASK_WIDTH-1:0] onehot,
  output logic                  any
);

  always_comb begin
    idx = '0;
    // Scan downward so the lowest set bit wins.
    for (int i = MASK_WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) idx = i[IDX_WIDTH-1:0];
    end
  end

  assign onehot = mask & (~mask + MASK_WIDTH'(1));
  assign any    = |mask;

endmodule

// File: rtl/axis_hit_splitter.sv
// Splits a merged 128-bit window word into one AXI-Stream beat per set mask bit.
// Optional macro AXIS_HIT_SPLITTER_EMPTY_BEAT_EN: zero-mask words emit one marker beat (index 0x7F).
module axis_hit_splitter
  import axis_hit_pkg::*;
(
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [CFG_WIDTH-1:0]          cfg,
  input  logic [MASK_WIDTH+HDR_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [OUT_W-1:0]              m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [STS_WIDTH-1:0]          sts_truncated
);

  state_t                 state, state_d;
  logic [MASK_WIDTH-1:0]  mask_q, mask_d;
  logic [HDR_WIDTH-1:0]   hdr_q, hdr_d;
  logic [CFG_WIDTH-1:0]   limit_q, limit_d;
  logic [CFG_WIDTH-1:0]   count_q, count_d;
  logic [STS_WIDTH-1:0]   trunc_q, trunc_d;

  logic [IDX_WIDTH-1:0]   enc_idx;
  logic [MASK_WIDTH-1:0]  enc_onehot;
  logic                   enc_any;

  logic [MASK_WIDTH-1:0]  rest;
  logic [MASK_WIDTH-1:0]  new_mask;
  logic                   limit_hit;
  logic                   last;
  logic                   scan;
  logic                   fire;
  logic                   accept;
  logic                   word_busy;
  logic [OUT_IDX_W-1:0]   idx_field;

  lsb_priority_encoder u_enc (
    .mask   (mask_q),
    .idx    (enc_idx),
    .onehot (enc_onehot),
    .any    (enc_any)
  );

  assign scan      = (state == ST_SCAN);
  assign rest      = mask_q & ~enc_onehot;
  assign limit_hit = (limit_q != '0) && ((count_q + CFG_WIDTH'(1)) == limit_q);
  assign last      = (rest == '0) || limit_hit;
  assign fire      = scan && m_axis_tready;
  assign new_mask  = s_axis_tdata[MASK_WIDTH-1:0];

  // A new word may be taken on the final handshake of the current one.
  assign s_axis_tready = !scan || (last && m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;

`ifdef AXIS_HIT_SPLITTER_EMPTY_BEAT_EN
  assign word_busy = 1'b1;
`else
  assign word_busy = |new_mask;
`endif

  always_comb begin
    state_d = state;
    mask_d  = mask_q;
    hdr_d   = hdr_q;
    limit_d = limit_q;
    count_d = count_q;
    trunc_d = trunc_q;

    if (fire) begin
      mask_d  = rest;
      count_d = count_q + CFG_WIDTH'(1);
      if (last) begin
        state_d = ST_IDLE;
        mask_d  = '0;
        if (limit_hit && (rest != '0) && (trunc_q != '1))
          trunc_d = trunc_q + STS_WIDTH'(1);
      end
    end

    if (accept) begin
      mask_d  = new_mask;
      hdr_d   = s_axis_tdata[MASK_WIDTH+HDR_WIDTH-1:MASK_WIDTH];
      limit_d = cfg;
      count_d = '0;
      state_d = word_busy ? ST_SCAN : ST_IDLE;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= ST_IDLE;
      mask_q  <= '0;
      hdr_q   <= '0;
      limit_q <= '0;
      count_q <= '0;
      trunc_q <= '0;
    end else begin
      state   <= state_d;
      mask_q  <= mask_d;
      hdr_q   <= hdr_d;
      limit_q <= limit_d;
      count_q <= count_d;
      trunc_q <= trunc_d;
    end
  end

  // An empty mask in SCAN only occurs for the window-boundary marker beat.
  assign idx_field     = enc_any ? OUT_IDX_W'(enc_idx) : EMPTY_IDX;
  assign m_axis_tdata  = {2'b00, hdr_q, idx_field};
  assign m_axis_tvalid = scan;
  assign m_axis_tlast  = scan && last;
  assign sts_truncated = trunc_q;

endmodule

// File: tb/tb_axis_hit_splitter.sv
// Directed bench for axis_hit_splitter with a queue-based beat model and per-cycle compare.
module tb_axis_hit_splitter;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [7:0]   cfg = 8'd0;
  logic [127:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [71:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic         m_tlast;
  logic [15:0]  sts;
  logic         toggle_mode = 1'b0;

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1;
    if (toggle_mode) m_tready = ~m_tready;
    else             m_tready = 1'b1;
  end

  axis_hit_splitter dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg           (cfg),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .sts_truncated (sts)
  );

  typedef struct {
    logic [7:0]  idx;
    logic [61:0] hdr;
    logic        last;
    logic        trunc;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       cur;
  int          checks = 0;
  int          errors = 0;
  int          exp_trunc = 0;
  int          cyc = 0;
  int          log_idx[$];
  int          log_last[$];
  int          log_cyc[$];
  logic [61:0] log_hdr[$];

  logic        prev_stall = 1'b0;
  logic [71:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, got timeout expected completion", name);
  endtask

  // Expected beats of one word, straight from the splitting rules.
  task automatic model_push(input logic [65:0] mask, input logic [61:0] hdr, input logic [7:0] c);
    int    set[$];
    int    lim;
    beat_t b;
    for (int i = 0; i < 66; i++) if (mask[i]) set.push_back(i);
    if (set.size() == 0) begin
`ifdef AXIS_HIT_SPLITTER_EMPTY_BEAT_EN
      b.idx = 8'h7F; b.hdr = hdr; b.last = 1'b1; b.trunc = 1'b0;
      exp_q.push_back(b);
`endif
      return;
    end
    lim = (c == 0 || int'(c) >= set.size()) ? set.size() : int'(c);
    for (int k = 0; k < lim; k++) begin
      b.idx   = 8'(set[k]);
      b.hdr   = hdr;
      b.last  = (k == lim - 1);
      b.trunc = (k == lim - 1) && (lim < set.size());
      exp_q.push_back(b);
    end
  endtask

  always @(negedge aclk) begin
    cyc++;
    if (areset) begin
      exp_q.delete();
      exp_trunc = 0;
      prev_stall = 1'b0;
    end else begin
      check("sts_truncated", 128'(sts), 128'(exp_trunc));
      check("m_tvalid", 128'(m_tvalid), 128'(exp_q.size() != 0));
      if (prev_stall) begin
        check("stall_hold_data", 128'(m_tdata), 128'(prev_data));
        check("stall_hold_last", 128'(m_tlast), 128'(prev_last));
      end
      if (m_tvalid && m_tready && exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        check("beat_data", 128'(m_tdata), 128'({2'b00, cur.hdr, cur.idx}));
        check("beat_last", 128'(m_tlast), 128'(cur.last));
        if (cur.trunc && exp_trunc != 65535) exp_trunc++;
        log_idx.push_back(int'(m_tdata[7:0]));
        log_last.push_back(int'(m_tlast));
        log_cyc.push_back(cyc);
        log_hdr.push_back(m_tdata[69:8]);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (s_tvalid && s_tready) model_push(s_tdata[65:0], s_tdata[127:66], cfg);
    end
  end

  task automatic clear_log();
    log_idx.delete(); log_last.delete(); log_cyc.delete(); log_hdr.delete();
  endtask

  task automatic send(input logic [65:0] mask, input logic [61:0] hdr, input logic [7:0] c);
    int   n = 0;
    logic got;
    s_tdata  = {hdr, mask};
    cfg      = c;
    s_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      got = s_tready;
      @(posedge aclk);
      #1;
      if (got) break;
      n++;
      if (n > 200) begin
        fail_timeout("send_accept");
        break;
      end
    end
    s_tvalid = 1'b0;
    cfg      = 8'd1;  // changes after acceptance must not affect the word in flight
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 300) begin
      @(posedge aclk);
      #1;
      n++;
    end
    if (n >= 300) fail_timeout("wait_idle");
    repeat (2) @(posedge aclk);
    #1;
  endtask

  logic [65:0] m;

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    check("rst_s_tready", 128'(s_tready), 128'(1));
    check("rst_m_tvalid", 128'(m_tvalid), 128'(0));
    check("rst_m_tlast", 128'(m_tlast), 128'(0));
    check("rst_sts", 128'(sts), 128'(0));

    // Two hits, unlimited
    clear_log();
    send(66'h5, 62'h1234, 8'd0);
    wait_idle();
    check("t1_count", 128'(log_idx.size()), 128'(2));
    if (log_idx.size() == 2) begin
      check("t1_idx0", 128'(log_idx[0]), 128'(0));
      check("t1_last0", 128'(log_last[0]), 128'(0));
      check("t1_idx1", 128'(log_idx[1]), 128'(2));
      check("t1_last1", 128'(log_last[1]), 128'(1));
      check("t1_hdr0", 128'(log_hdr[0]), 128'h1234);
      check("t1_hdr1", 128'(log_hdr[1]), 128'h1234);
    end
    check("t1_s_tready", 128'(s_tready), 128'(1));

    // Truncation by limit 2
    check("t2_sts_before", 128'(sts), 128'(0));
    clear_log();
    m = '0; m[3] = 1'b1; m[10] = 1'b1; m[65] = 1'b1;
    send(m, 62'h3000_0000_0000_ABCD, 8'd2);
    wait_idle();
    check("t2_count", 128'(log_idx.size()), 128'(2));
    if (log_idx.size() == 2) begin
      check("t2_idx0", 128'(log_idx[0]), 128'(3));
      check("t2_idx1", 128'(log_idx[1]), 128'(10));
      check("t2_last1", 128'(log_last[1]), 128'(1));
    end
    check("t2_sts_after", 128'(sts), 128'(1));

    // Back-to-back words
    clear_log();
    send(66'h1, 62'hA, 8'd0);
    send(66'h6, 62'hB, 8'd0);
    wait_idle();
    check("t3_count", 128'(log_idx.size()), 128'(3));
    if (log_idx.size() == 3) begin
      check("t3_idx0", 128'(log_idx[0]), 128'(0));
      check("t3_idx1", 128'(log_idx[1]), 128'(1));
      check("t3_idx2", 128'(log_idx[2]), 128'(2));
      check("t3_gap01", 128'(log_cyc[1] - log_cyc[0]), 128'(1));
      check("t3_gap12", 128'(log_cyc[2] - log_cyc[1]), 128'(1));
      check("t3_hdr2", 128'(log_hdr[2]), 128'hB);
    end

    // Backpressure toggling
    clear_log();
    toggle_mode = 1'b1;
    send(66'hF, 62'h77, 8'd0);
    wait_idle();
    toggle_mode = 1'b0;
    check("t4_count", 128'(log_idx.size()), 128'(4));
    if (log_idx.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t4_idx", 128'(log_idx[i]), 128'(i));
      check("t4_last3", 128'(log_last[3]), 128'(1));
    end

    // Highest index
    clear_log();
    m = '0; m[65] = 1'b1;
    send(m, 62'h5, 8'd0);
    wait_idle();
    check("t5_count", 128'(log_idx.size()), 128'(1));
    if (log_idx.size() == 1) check("t5_idx", 128'(log_idx[0]), 128'h41);

    // Limit 1 and limit >= popcount
    clear_log();
    send(66'h6, 62'h9, 8'd1);
    send(66'h7, 62'h9, 8'd3);
    wait_idle();
    check("t6_count", 128'(log_idx.size()), 128'(4));
    if (log_idx.size() == 4) begin
      check("t6_idx0", 128'(log_idx[0]), 128'(1));
      check("t6_last0", 128'(log_last[0]), 128'(1));
      check("t6_idx3", 128'(log_idx[3]), 128'(2));
    end
    check("t6_sts", 128'(sts), 128'(2));

    // Zero-mask word
    clear_log();
    send(66'h0, 62'h55, 8'd0);
    wait_idle();
`ifdef AXIS_HIT_SPLITTER_EMPTY_BEAT_EN
    check("t7_count", 128'(log_idx.size()), 128'(1));
    if (log_idx.size() == 1) begin
      check("t7_idx", 128'(log_idx[0]), 128'h7F);
      check("t7_last", 128'(log_last[0]), 128'(1));
      check("t7_hdr", 128'(log_hdr[0]), 128'h55);
    end
`else
    check("t7_count", 128'(log_idx.size()), 128'(0));
`endif

    // Reset mid-word
    clear_log();
    send(66'hFF, 62'h66, 8'd0);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    check("t8_m_tvalid", 128'(m_tvalid), 128'(0));
    check("t8_s_tready", 128'(s_tready), 128'(1));
    check("t8_sts", 128'(sts), 128'(0));
    repeat (10) @(posedge aclk);
    #1;
    check("t8_count", 128'(log_idx.size()), 128'(1));
    if (log_idx.size() == 1) check("t8_idx0", 128'(log_idx[0]), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_hit_splitter.md
Name: axis_hit_splitter

Overview:
- Inverse of the window accumulator: takes one merged 128-bit window word and splits it back into per-hit beats.
- Word layout: bits [65:0] are the OR-merged hit mask; bits [127:66] are the 62-bit window header.
- Emits one AXI-Stream beat per set mask bit, lowest index first, with backpressure and tlast on the final hit of the word.
- Sits between the window accumulator output and the per-channel event logger/DMA.

Parameters:
- MASK_WIDTH, 66, number of hit-mask bits at the bottom of the input word.
- HDR_WIDTH, 62, header bits above the mask (MASK_WIDTH+HDR_WIDTH = 128).
- IDX_WIDTH, 7, channel index width, ceil(log2(MASK_WIDTH)).
- STS_WIDTH, 16, width of the saturating truncation counter.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- cfg  in  8  max hits emitted per word; 0 = unlimited; latched at word acceptance
- s_axis_tdata  in  128  merged window word
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  72  [7:0] index zero-extended from IDX_WIDTH; [69:8] header; [71:70] = 0
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last beat of the current word
- sts_truncated  out  16  saturating count of words cut short by cfg

Behaviour:
- Reset: one clock and one reset, both fixed: aclk, synchronous active-high areset.
- Reset values: state IDLE, mask/header/limit/hit count = 0, m_axis_tvalid = 0, m_axis_tlast = 0, sts_truncated = 0, s_axis_tready = 1 in the first cycle after reset.
- Reset mid-word discards the word with no further beats; reset dominates every other event.
- States:
  - IDLE: s_axis_tready = 1. On s_axis_tvalid, latch mask, header, limit = cfg, hit count = 0. Nonzero mask -> SCAN. Zero mask -> word dropped, stay IDLE.
  - SCAN: m_axis_tvalid = 1. m_axis_tdata index = lowest set bit of the mask register (combinational from registers).
- Beat completion: on m_axis_tvalid & m_axis_tready, clear that mask bit and increment hit count.
- last = (mask with current bit cleared == 0) | (limit != 0 & count+1 == limit). m_axis_tlast = last.
- Truncation: if last is due to the limit while other mask bits remain, remaining bits are discarded and sts_truncated increments (saturates at all-ones).
- s_axis_tready = IDLE | (SCAN & last & m_axis_tready), so words can be accepted back-to-back:
  - Accepting on the last handshake loads the new word in the same edge.
  - Nonzero new mask -> stay in SCAN; zero new mask -> go to IDLE.
- Latency: word accepted at edge N gives its first beat valid from cycle N+1. Throughput is 1 hit per cycle, with no bubble between words.
- While m_axis_tvalid & !m_axis_tready, m_axis_tdata and m_axis_tlast are held stable.
- cfg changes mid-word have no effect until the next acceptance.
- Limit of 1 emits only the lowest hit. cfg >= popcount behaves as unlimited.
- Index MASK_WIDTH-1 = 65 is legal: index field = 0x41.

Optional Feature:
- Macro AXIS_HIT_SPLITTER_EMPTY_BEAT_EN.
- Defined: a zero-mask word is not dropped; it enters SCAN and emits one beat with index 0x7F, m_axis_tlast = 1, and the header, marking the window boundary.
- Undefined: zero-mask words are consumed in IDLE with no output beat.

Decomposition:
- Package axis_hit_pkg: MASK_WIDTH, HDR_WIDTH, IDX_WIDTH, the 0x7F empty index constant, and the output field bit offsets.
- One sub-module, lsb_priority_encoder:
  - Inputs: MASK_WIDTH vector.
  - Outputs: index of the lowest set bit, a one-hot clear mask, and an any-set flag.
  - Purely combinational.

Test Plan:
- Mask 0x5 (bits 0,2), header 0x1234, cfg 0, ready held 1 -> beats idx 0 (tlast 0), idx 2 (tlast 1), both with header 0x1234; tready high again the next cycle.
- Mask bits {3,10,65}, cfg 2 -> idx 3 and idx 10, tlast on idx 10; bit 65 never emitted; sts_truncated 0 -> 1.
- Two words back-to-back (masks 0x1 then 0x6) with tvalid held 1 -> idx 0, 1, 2 on three consecutive cycles, with no idle cycle between words.
- m_axis_tready toggling 1/0 on mask 0xF -> data/tlast stable while stalled; exactly 4 beats, idx 0..3.
- Zero-mask word -> no beat without the macro; with the macro, one beat idx 0x7F, tlast 1, header correct.
- areset asserted after the first beat of mask 0xFF -> next cycle m_axis_tvalid 0, s_axis_tready 1, sts_truncated 0; no residual beats.
